// File: rtl/pixel_grid_tracker.sv
// Tracks the pixel position in a video stream and splits the frame into a grid of sections.
// Define PIXEL_GRID_TRACKER_ERR_EN to add the sticky sync_err_o output.
module pixel_grid_tracker #(
  parameter int X_RESOLUTION   = 640,
  parameter int Y_RESOLUTION   = 480,
  parameter int X_NUM_SECTIONS = 4,
  parameter int Y_NUM_SECTIONS = 4
) (
  input  logic                                                          clk_i,
  input  logic                                                          rst_i,
  input  logic                                                          valid_i,
  input  logic                                                          ready_i,
  input  logic                                                          hsync_i,
  input  logic                                                          vsync_i,
  input  logic                                                          vde_i,
  output logic [$clog2(X_RESOLUTION)-1:0]                               x_o,
  output logic [$clog2(Y_RESOLUTION)-1:0]                               y_o,
  output logic [((X_NUM_SECTIONS > 1) ? $clog2(X_NUM_SECTIONS) : 1)-1:0] x_section_o,
  output logic [((Y_NUM_SECTIONS > 1) ? $clog2(Y_NUM_SECTIONS) : 1)-1:0] y_section_o,
  output logic                                                          x_edge_o,
  output logic                                                          y_edge_o,
  output logic                                                          frame_end_o
`ifdef PIXEL_GRID_TRACKER_ERR_EN
  ,
  output logic                                                          sync_err_o
`endif
);

  localparam int XW        = $clog2(X_RESOLUTION);
  localparam int YW        = $clog2(Y_RESOLUTION);
  localparam int X_SEC_LEN = X_RESOLUTION / X_NUM_SECTIONS;
  localparam int Y_SEC_LEN = Y_RESOLUTION / Y_NUM_SECTIONS;
  localparam int XLW       = (X_SEC_LEN > 1) ? $clog2(X_SEC_LEN) : 1;
  localparam int YLW       = (Y_SEC_LEN > 1) ? $clog2(Y_SEC_LEN) : 1;

  localparam logic [XW-1:0]  X_LAST  = XW'(X_RESOLUTION - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(Y_RESOLUTION - 1);
  localparam logic [XLW-1:0] XL_LAST = XLW'(X_SEC_LEN - 1);
  localparam logic [YLW-1:0] YL_LAST = YLW'(Y_SEC_LEN - 1);

  logic [XLW-1:0] xs_q;
  logic [YLW-1:0] ys_q;
  logic           beat;
  logic           pixel_beat;
  logic           vsync_beat;
  logic           hsync_beat;
  logic           x_wrap;
  logic           y_wrap;
  logic           xs_wrap;
  logic           ys_wrap;

  // vsync wins over hsync; any sync marker on an active pixel is ignored
  assign beat       = valid_i & ready_i;
  assign pixel_beat = beat & vde_i;
  assign vsync_beat = beat & ~vde_i & vsync_i;
  assign hsync_beat = beat & ~vde_i & hsync_i & ~vsync_i;

  assign x_wrap  = (x_o == X_LAST);
  assign y_wrap  = (y_o == Y_LAST);
  assign xs_wrap = (xs_q == XL_LAST);
  assign ys_wrap = (ys_q == YL_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_o         <= '0;
      y_o         <= '0;
      xs_q        <= '0;
      ys_q        <= '0;
      x_section_o <= '0;
      y_section_o <= '0;
    end else if (pixel_beat) begin
      if (x_wrap) begin
        x_o         <= '0;
        xs_q        <= '0;
        x_section_o <= '0;
        if (y_wrap) begin
          y_o         <= '0;
          ys_q        <= '0;
          y_section_o <= '0;
        end else begin
          y_o <= y_o + 1'b1;
          if (ys_wrap) begin
            ys_q        <= '0;
            y_section_o <= y_section_o + 1'b1;
          end else begin
            ys_q <= ys_q + 1'b1;
          end
        end
      end else begin
        x_o <= x_o + 1'b1;
        if (xs_wrap) begin
          xs_q        <= '0;
          x_section_o <= x_section_o + 1'b1;
        end else begin
          xs_q <= xs_q + 1'b1;
        end
      end
    end else if (vsync_beat) begin
      x_o         <= '0;
      y_o         <= '0;
      xs_q        <= '0;
      ys_q        <= '0;
      x_section_o <= '0;
      y_section_o <= '0;
    end else if (hsync_beat) begin
      x_o         <= '0;
      xs_q        <= '0;
      x_section_o <= '0;
    end
  end

  // Edge pulses are recomputed every cycle so they last exactly one cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_edge_o    <= 1'b0;
      y_edge_o    <= 1'b0;
      frame_end_o <= 1'b0;
    end else begin
      x_edge_o    <= pixel_beat & xs_wrap;
      y_edge_o    <= pixel_beat & x_wrap & ys_wrap;
      frame_end_o <= pixel_beat & x_wrap & y_wrap;
    end
  end

`ifdef PIXEL_GRID_TRACKER_ERR_EN
  // A sync marker that lands away from the start of a line/frame means the source slipped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_err_o <= 1'b0;
    end else if ((hsync_beat && (x_o != '0)) ||
                 (vsync_beat && ((x_o != '0) || (y_o != '0)))) begin
      sync_err_o <= 1'b1;
    end
  end
`else
  // Sync error tracking is compiled out in this build.
`endif

endmodule

// File: tb/tb_pixel_grid_tracker.sv
// Self-checking bench for pixel_grid_tracker on a small 8x4 frame with a 4x2 section grid.
// Table vectors and a behavioural reference model both feed an expected-result scoreboard.
module tb_pixel_grid_tracker;

  localparam int XR = 8;
  localparam int YR = 4;
  localparam int XN = 4;
  localparam int YN = 2;
  localparam int XL = XR / XN;
  localparam int YL = YR / YN;

  typedef struct {
    int x;
    int y;
    int xsec;
    int ysec;
    bit xe;
    bit ye;
    bit fe;
    bit err;
  } exp_t;

  typedef struct {
    bit   rst;
    bit   valid;
    bit   ready;
    bit   hs;
    bit   vs;
    bit   vde;
    exp_t e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic       hsync;
  logic       vsync;
  logic       vde;
  logic [2:0] x;
  logic [1:0] y;
  logic [1:0] x_sec;
  logic [0:0] y_sec;
  logic       x_edge;
  logic       y_edge;
  logic       frame_end;
  logic       sync_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mx       = 0;
  int   my       = 0;
  bit   merr     = 1'b0;
  exp_t sb[$];
  vec_t vecs[$];

  pixel_grid_tracker #(
    .X_RESOLUTION  (XR),
    .Y_RESOLUTION  (YR),
    .X_NUM_SECTIONS(XN),
    .Y_NUM_SECTIONS(YN)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid),
    .ready_i    (ready),
    .hsync_i    (hsync),
    .vsync_i    (vsync),
    .vde_i      (vde),
    .x_o        (x),
    .y_o        (y),
    .x_section_o(x_sec),
    .y_section_o(y_sec),
    .x_edge_o   (x_edge),
    .y_edge_o   (y_edge),
    .frame_end_o(frame_end)
`ifdef PIXEL_GRID_TRACKER_ERR_EN
    ,
    .sync_err_o (sync_err)
`endif
  );

`ifndef PIXEL_GRID_TRACKER_ERR_EN
  assign sync_err = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit v, bit rd, bit hs, bit vs, bit de,
                              int ex, int ey, int exs, int eys,
                              bit exe, bit eye, bit efe, bit eerr);
    vec_t t;
    t.rst = r; t.valid = v; t.ready = rd; t.hs = hs; t.vs = vs; t.vde = de;
    t.e.x = ex; t.e.y = ey; t.e.xsec = exs; t.e.ysec = eys;
    t.e.xe = exe; t.e.ye = eye; t.e.fe = efe; t.e.err = eerr;
    return t;
  endfunction

  // Reference model works on plain integer coordinates and derives sections by division
  task automatic model_step(input bit r, input bit v, input bit rd, input bit hs,
                            input bit vs, input bit de, output exp_t e);
    e.xe = 1'b0; e.ye = 1'b0; e.fe = 1'b0;
    if (r) begin
      mx = 0; my = 0; merr = 1'b0;
    end else if (v && rd) begin
      if (de) begin
        e.xe = ((mx % XL) == XL - 1);
        e.ye = (mx == XR - 1) && ((my % YL) == YL - 1);
        e.fe = (mx == XR - 1) && (my == YR - 1);
        mx++;
        if (mx == XR) begin
          mx = 0;
          my = (my + 1) % YR;
        end
      end else if (vs) begin
        if (mx != 0 || my != 0) merr = 1'b1;
        mx = 0; my = 0;
      end else if (hs) begin
        if (mx != 0) merr = 1'b1;
        mx = 0;
      end
    end
    e.x = mx; e.y = my; e.xsec = mx / XL; e.ysec = my / YL; e.err = merr;
  endtask

  task automatic cmp(input string name, input integer act, input integer expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e = sb.pop_front();
    cmp("x_o", x, e.x);
    cmp("y_o", y, e.y);
    cmp("x_section_o", x_sec, e.xsec);
    cmp("y_section_o", y_sec, e.ysec);
    cmp("x_edge_o", x_edge, e.xe);
    cmp("y_edge_o", y_edge, e.ye);
    cmp("frame_end_o", frame_end, e.fe);
`ifdef PIXEL_GRID_TRACKER_ERR_EN
    cmp("sync_err_o", sync_err, e.err);
`endif
  endtask

  // Drives one cycle; use_tab selects the hand-written expectation over the model's
  task automatic applyStimulus(input bit r, input bit v, input bit rd, input bit hs,
                               input bit vs, input bit de, input bit use_tab,
                               input exp_t tab);
    exp_t m;
    rst = r; valid = v; ready = rd; hsync = hs; vsync = vs; vde = de;
    model_step(r, v, rd, hs, vs, de, m);
    sb.push_back(use_tab ? tab : m);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic drive(input bit r, input bit v, input bit rd, input bit hs,
                       input bit vs, input bit de);
    exp_t unused;
    unused = '{default: 0};
    applyStimulus(r, v, rd, hs, vs, de, 1'b0, unused);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; ready = 1'b0; hsync = 1'b0; vsync = 1'b0; vde = 1'b0;
    $display("[TB] start");

    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 0,0,0,0));
    // First line: x_edge after every second pixel, wrap to y=1
    vecs.push_back(mk(0,1,1,0,0,1, 1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,1, 2,0,1,0, 1,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,1, 3,0,1,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,1, 4,0,2,0, 1,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,1, 5,0,2,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,1, 6,0,3,0, 1,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,1, 7,0,3,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,1, 0,1,0,0, 1,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,1,1,1,1, 0,1,0,0, 0,0,0,0));
    // Second line under backpressure: stalls hold state and never pulse
    for (int k = 1; k <= 8; k++) begin
      vecs.push_back(mk(0,1,0,0,0,1, (k-1)%8, 1, ((k-1)%8)/2, 0, 0,0,0,0));
      if (k < 8)
        vecs.push_back(mk(0,1,1,0,0,1, k, 1, k/2, 0, (k%2)==0, 0,0,0));
      else
        vecs.push_back(mk(0,1,1,0,0,1, 0, 2, 0, 1, 1, 1, 0, 0));
    end
    // Early hsync on line 2, a gated hsync, then sync markers on a pixel beat
    vecs.push_back(mk(0,1,1,0,0,1, 1,2,0,1, 0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,1, 2,2,1,1, 1,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,1, 3,2,1,1, 0,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,0, 3,2,1,1, 0,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0, 0,2,0,1, 0,0,0,1));
    vecs.push_back(mk(0,1,1,1,1,1, 1,2,0,1, 0,0,0,1));

    foreach (vecs[i])
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].ready, vecs[i].hs,
                    vecs[i].vs, vecs[i].vde, 1'b1, vecs[i].e);

    // Full frame from reset: y_edge at pixels 15 and 31, frame_end once, then all zero
    drive(1,0,0,0,0,0);
    for (int i = 0; i < XR * YR; i++) drive(0,1,1,0,0,1);
    drive(0,0,0,0,0,0);

    // Simultaneous hsync+vsync at (5,2)
    drive(1,0,0,0,0,0);
    for (int i = 0; i < 2 * XR + 5; i++) drive(0,1,1,0,0,1);
    drive(0,1,1,1,1,0);
    drive(0,1,1,0,0,1);

    // Reset during a pixel beat at (3,1) suppresses the pulse and clears position
    drive(1,0,0,0,0,0);
    for (int i = 0; i < XR + 3; i++) drive(0,1,1,0,0,1);
    drive(1,1,1,0,0,1);
    drive(0,1,1,0,0,1);

    // Randomised traffic with occasional syncs and resets
    drive(1,0,0,0,0,0);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0,99) == 0, $urandom_range(0,3) != 0, $urandom_range(0,3) != 0,
            $urandom_range(0,15) == 0, $urandom_range(0,31) == 0, $urandom_range(0,7) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
